// File: rtl/seq_mult_ctrl_if.sv
// Start/done handshake and operand/result bus between a requester and seq_mult_ctrl.
interface seq_mult_ctrl_if #(
   parameter int unsigned W = 8
);
   logic           start;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           busy;
   logic           done;
   logic [2*W-1:0] product;

   modport master (
      output start, a, b,
      input  busy, done, product
   );

   modport slave (
      input  start, a, b,
      output busy, done, product
   );
endinterface

// File: rtl/seq_mult_ctrl.sv
// Shift-add unsigned multiplier controller: one W-bit adder row reused for W cycles.
// Optional macro EARLY_TERM_EN ends RUN once the remaining multiplier bits are all zero.
module seq_mult_ctrl #(
   parameter int unsigned W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   seq_mult_ctrl_if.slave bus
);
   localparam int unsigned CW = $clog2(W + 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e         state_q, state_d;
   logic [W-1:0]   m_q, m_d;
   logic [W-1:0]   acc_q, acc_d;
   logic [W-1:0]   q_q, q_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*W-1:0] prod_q, prod_d;

   logic [W:0]     sum;
   logic [W-1:0]   acc_n, q_n;
   logic [2*W-1:0] aligned;
   logic           last;
`ifdef EARLY_TERM_EN
   logic [CW-1:0]  rem;
   logic [W-1:0]   pending;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         m_q     <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
      end
   end

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      acc_d   = acc_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;

      // Masked adder row; the carry-out shifts into ACC so nothing is lost.
      sum   = {1'b0, acc_q} + {1'b0, m_q & {W{q_q[0]}}};
      acc_n = sum[W:1];
      q_n   = {sum[0], q_q[W-1:1]};
`ifdef EARLY_TERM_EN
      rem     = CW'(W - 1) - cnt_q;
      pending = q_n & ({W{1'b1}} >> (cnt_q + CW'(1)));
      last    = (pending == '0);
      aligned = {acc_n, q_n} >> rem;
`else
      last    = (cnt_q == CW'(W - 1));
      aligned = {acc_n, q_n};
`endif

      case (state_q)
         StIdle, StDone: begin
            if (bus.start) begin
               state_d = StRun;
               m_d     = bus.a;
               q_d     = bus.b;
               acc_d   = '0;
               cnt_d   = '0;
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            acc_d = acc_n;
            q_d   = q_n;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
               state_d         = StDone;
               {acc_d, q_d}    = aligned;
               prod_d          = aligned;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.busy    = (state_q == StRun);
   assign bus.done    = (state_q == StDone);
   assign bus.product = prod_q;
endmodule
